// File: rtl/sccb_bus_arbiter_pkg.sv
// Shared definitions for the system-init SCCB arbiter: field widths, FSM state encoding
// and a constant-evaluable log2 helper.
package sccb_bus_arbiter_pkg;

  localparam int unsigned CHIP_W = 7;
  localparam int unsigned REG_W  = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StIssue = S_ISSUE,
    StWait  = S_WAIT,
    StResp  = S_RESP
  } arb_state_e;

  // Index width for n items; never below 1 so a 1-bit index still exists for n <= 2.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sccb_bus_arbiter_if.sv
// Requester-side and master-side handshake bundle of the SCCB arbiter.
// slave: the arbiter's view. master: the environment (requesters + byte engine).
interface sccb_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  import sccb_bus_arbiter_pkg::*;

  localparam int unsigned IdxW = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [CHIP_W*NUM_REQ-1:0] req_chip;
  logic [REG_W*NUM_REQ-1:0]  req_reg;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_rd;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      m_cmd_valid;
  logic                      m_cmd_ready;
  logic [CHIP_W-1:0]         m_chip;
  logic [REG_W-1:0]          m_reg;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_rd;
  logic                      m_done;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_nack;
  logic                      m_abort;
  logic [IdxW-1:0]           grant_id;
  logic                      busy;

  modport slave (
    input  req_valid, req_chip, req_reg, req_wdata, req_rd,
    input  m_cmd_ready, m_done, m_rdata, m_nack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_cmd_valid, m_chip, m_reg, m_wdata, m_rd, m_abort, grant_id, busy
  );

  modport master (
    output req_valid, req_chip, req_reg, req_wdata, req_rd,
    output m_cmd_ready, m_done, m_rdata, m_nack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_cmd_valid, m_chip, m_reg, m_wdata, m_rd, m_abort, grant_id, busy
  );

endinterface

// File: rtl/sccb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr+1, wrapping.
module rr_pick
  import sccb_bus_arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  // Scan farthest-to-nearest so the nearest requester after ptr overwrites the others.
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = int'(N); k >= 1; k--) begin
      j = (int'(ptr_i) + k) % int'(N);
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sccb_bus_arbiter.sv
// Time-shares one SCCB byte engine between NUM_REQ init sequencers. Round-robin grant held
// for one full register transaction, with a watchdog that aborts a hung master.
module sccb_bus_arbiter
  import sccb_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TO_W    = 20,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic               clk,
  input logic               reset,
  sccb_bus_arbiter_if.slave bus
);

  localparam int unsigned     IdxW   = clog2(NUM_REQ);
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] PtrRst = IdxW'(NUM_REQ - 1);

  arb_state_e          state_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     grant_q;
  logic [CHIP_W-1:0]   chip_q;
  logic [REG_W-1:0]    reg_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rd_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [TO_W-1:0]     cnt_q;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;
  logic                timeout_hit;

  rr_pick #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Watchdog expiry; a completion landing on the expiry cycle in WAIT takes priority.
  always_comb begin
    timeout_hit = 1'b0;
    if (state_q == StIssue) begin
      timeout_hit = (cnt_q == ToLast);
    end else if (state_q == StWait) begin
      timeout_hit = (cnt_q == ToLast) && !bus.m_done;
    end
  end

  // Transaction FSM with field/result latches and watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= PtrRst;
      grant_q <= '0;
      chip_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            ptr_q   <= pick_idx;
            chip_q  <= bus.req_chip[int'(pick_idx)*CHIP_W +: CHIP_W];
            reg_q   <= bus.req_reg[int'(pick_idx)*REG_W +: REG_W];
            wdata_q <= bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            rd_q    <= bus.req_rd[pick_idx];
            cnt_q   <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= StResp;
          end else if (bus.m_cmd_ready) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.m_done) begin
            rdata_q <= bus.m_rdata;
            err_q   <= bus.m_nack;
            state_q <= StResp;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Pulses are masked during reset so an in-flight transaction dies silently.
  assign bus.req_ready   = (state_q == StIdle && !reset) ? pick_gnt : '0;
  assign bus.rsp_valid   = (state_q == StResp && !reset) ? (NUM_REQ'(1) << grant_q) : '0;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.m_cmd_valid = (state_q == StIssue);
  assign bus.m_chip      = chip_q;
  assign bus.m_reg       = reg_q;
  assign bus.m_wdata     = wdata_q;
  assign bus.m_rd        = rd_q;
  assign bus.m_abort     = timeout_hit && !reset;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q != StIdle);

endmodule
